// File: rtl/nasti_dma_sequencer.sv
// nasti_dma_sequencer
// Queues DMA descriptors in a small FIFO and feeds them one at a time to a
// data mover. Each job is checked for 8-byte alignment and a non-zero
// length, then started with a single-cycle pulse. The sequencer watches
// the mover's done line for acknowledge and completion, and reports each
// finished job on a valid/ready completion channel.
module nasti_dma_sequencer #(
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic                      desc_valid,
    output logic                      desc_ready,
    input  logic [ADDR_WIDTH-1:0]     desc_src,
    input  logic [ADDR_WIDTH-1:0]     desc_dest,
    input  logic [ADDR_WIDTH-1:0]     desc_len,
    input  logic [7:0]                desc_mask,
    input  logic [3:0]                desc_tag,

    output logic [ADDR_WIDTH-1:0]     mv_src_addr,
    output logic [ADDR_WIDTH-1:0]     mv_dest_addr,
    output logic [ADDR_WIDTH-1:0]     mv_length,
    output logic [7:0]                mv_mask,
    output logic                      mv_en,
    input  logic                      mv_done,

    output logic                      cpl_valid,
    input  logic                      cpl_ready,
    output logic [3:0]                cpl_tag,
    output logic                      cpl_err,

    output logic                      busy,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CHECK     = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_CPL       = 3'd5;

    // Number of WAIT_ACK cycles with done still high before giving up.
    localparam logic [2:0] ACK_LIMIT = 3'd7;

    // Descriptor storage (data only, no reset needed)
    logic [ADDR_WIDTH-1:0] fifo_src_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_dest_q [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_len_q  [DEPTH];
    logic [7:0]            fifo_mask_q [DEPTH];
    logic [3:0]            fifo_tag_q  [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic [2:0] state_q, state_d;
    logic [2:0] timer_q, timer_d;

    logic [ADDR_WIDTH-1:0] job_src_q, job_src_d;
    logic [ADDR_WIDTH-1:0] job_dest_q, job_dest_d;
    logic [ADDR_WIDTH-1:0] job_len_q, job_len_d;
    logic [7:0]            job_mask_q, job_mask_d;
    logic [3:0]            job_tag_q, job_tag_d;

    logic [ADDR_WIDTH-1:0] mv_src_q, mv_src_d;
    logic [ADDR_WIDTH-1:0] mv_dest_q, mv_dest_d;
    logic [ADDR_WIDTH-1:0] mv_len_q, mv_len_d;
    logic [7:0]            mv_mask_q, mv_mask_d;

    logic [3:0] cpl_tag_q, cpl_tag_d;
    logic       cpl_err_q, cpl_err_d;

    logic push;
    logic pop;
    logic job_invalid;

    assign desc_ready = (count_q < DEPTH_C);
    assign push       = desc_valid & desc_ready;
    assign pop        = (state_q == S_IDLE) & (count_q != '0);

    assign job_invalid = (job_len_q == '0)
                       | (job_len_q[2:0]  != 3'b000)
                       | (job_src_q[2:0]  != 3'b000)
                       | (job_dest_q[2:0] != 3'b000);

    // Write accepted descriptors into the slot under the write pointer
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_src_q[wr_ptr_q]  <= desc_src;
            fifo_dest_q[wr_ptr_q] <= desc_dest;
            fifo_len_q[wr_ptr_q]  <= desc_len;
            fifo_mask_q[wr_ptr_q] <= desc_mask;
            fifo_tag_q[wr_ptr_q]  <= desc_tag;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Job sequencing: next state plus the job, mover and completion registers
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        job_src_d  = job_src_q;
        job_dest_d = job_dest_q;
        job_len_d  = job_len_q;
        job_mask_d = job_mask_q;
        job_tag_d  = job_tag_q;
        mv_src_d   = mv_src_q;
        mv_dest_d  = mv_dest_q;
        mv_len_d   = mv_len_q;
        mv_mask_d  = mv_mask_q;
        cpl_tag_d  = cpl_tag_q;
        cpl_err_d  = cpl_err_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d    = S_CHECK;
                    job_src_d  = fifo_src_q[rd_ptr_q];
                    job_dest_d = fifo_dest_q[rd_ptr_q];
                    job_len_d  = fifo_len_q[rd_ptr_q];
                    job_mask_d = fifo_mask_q[rd_ptr_q];
                    job_tag_d  = fifo_tag_q[rd_ptr_q];
                end
            end
            S_CHECK: begin
                if (job_invalid) begin
                    state_d   = S_CPL;
                    cpl_tag_d = job_tag_q;
                    cpl_err_d = 1'b1;
                end else if (mv_done) begin
                    state_d   = S_ISSUE;
                    mv_src_d  = job_src_q;
                    mv_dest_d = job_dest_q;
                    mv_len_d  = job_len_q;
                    mv_mask_d = job_mask_q;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_ACK;
                timer_d = '0;
            end
            S_WAIT_ACK: begin
                if (!mv_done) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == ACK_LIMIT) begin
                    state_d   = S_CPL;
                    cpl_tag_d = job_tag_q;
                    cpl_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (mv_done) begin
                    state_d   = S_CPL;
                    cpl_tag_d = job_tag_q;
                    cpl_err_d = 1'b0;
                end
            end
            S_CPL: begin
                if (cpl_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register the sequencer state; reset discards any job in flight
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            job_src_q  <= '0;
            job_dest_q <= '0;
            job_len_q  <= '0;
            job_mask_q <= '0;
            job_tag_q  <= '0;
            mv_src_q   <= '0;
            mv_dest_q  <= '0;
            mv_len_q   <= '0;
            mv_mask_q  <= '0;
            cpl_tag_q  <= '0;
            cpl_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            job_src_q  <= job_src_d;
            job_dest_q <= job_dest_d;
            job_len_q  <= job_len_d;
            job_mask_q <= job_mask_d;
            job_tag_q  <= job_tag_d;
            mv_src_q   <= mv_src_d;
            mv_dest_q  <= mv_dest_d;
            mv_len_q   <= mv_len_d;
            mv_mask_q  <= mv_mask_d;
            cpl_tag_q  <= cpl_tag_d;
            cpl_err_q  <= cpl_err_d;
        end
    end

    assign mv_src_addr  = mv_src_q;
    assign mv_dest_addr = mv_dest_q;
    assign mv_length    = mv_len_q;
    assign mv_mask      = mv_mask_q;
    assign mv_en        = (state_q == S_ISSUE);

    assign cpl_valid = (state_q == S_CPL);
    assign cpl_tag   = cpl_tag_q;
    assign cpl_err   = cpl_err_q;

    assign busy  = (state_q != S_IDLE) | (count_q != '0);
    assign count = count_q;

endmodule

// File: tb/tb_nasti_dma_sequencer.sv
// Testbench for nasti_dma_sequencer: a mover model answers job pulses,
// and a scoreboard holds the expected completions and issued jobs.
module tb_nasti_dma_sequencer;

    typedef struct {
        logic [63:0] src;
        logic [63:0] dest;
        logic [63:0] len;
        logic [7:0]  mask;
        logic [3:0]  tag;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [3:0] tag;
        logic       err;
    } cpl_t;

    typedef struct {
        logic [63:0] src;
        logic [63:0] dest;
        logic [63:0] len;
        logic [7:0]  mask;
    } job_t;

    logic        aclk;
    logic        areset;
    logic        desc_valid;
    logic        desc_ready;
    logic [63:0] desc_src;
    logic [63:0] desc_dest;
    logic [63:0] desc_len;
    logic [7:0]  desc_mask;
    logic [3:0]  desc_tag;
    logic [63:0] mv_src_addr;
    logic [63:0] mv_dest_addr;
    logic [63:0] mv_length;
    logic [7:0]  mv_mask;
    logic        mv_en;
    logic        mv_done = 1'b1;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [3:0]  cpl_tag;
    logic        cpl_err;
    logic        busy;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    int mvEnCount = 0;
    int cplCount = 0;

    cpl_t expQ[$];
    job_t expJobQ[$];
    cpl_t monCpl;
    job_t monJob;
    logic [63:0] lastLen = '0;

    bit moverStuck = 0;
    bit moverBusy = 0;
    int moverCnt = 0;

    vec_t vecs[7];
    int waits;
    int bpWaits;
    bit bpDone;
    int k;
    bit found;
    int beforeEn;
    int beforeCpl;

    nasti_dma_sequencer #(.ADDR_WIDTH(64), .DEPTH(4)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .desc_valid   (desc_valid),
        .desc_ready   (desc_ready),
        .desc_src     (desc_src),
        .desc_dest    (desc_dest),
        .desc_len     (desc_len),
        .desc_mask    (desc_mask),
        .desc_tag     (desc_tag),
        .mv_src_addr  (mv_src_addr),
        .mv_dest_addr (mv_dest_addr),
        .mv_length    (mv_length),
        .mv_mask      (mv_mask),
        .mv_en        (mv_en),
        .mv_done      (mv_done),
        .cpl_valid    (cpl_valid),
        .cpl_ready    (cpl_ready),
        .cpl_tag      (cpl_tag),
        .cpl_err      (cpl_err),
        .busy         (busy),
        .count        (count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic [63:0] src, input logic [63:0] dest,
                                   input logic [63:0] len, input logic [7:0] mask,
                                   input logic [3:0] tag, input logic expErr);
        vec_t v;
        v.src = src;
        v.dest = dest;
        v.len = len;
        v.mask = mask;
        v.tag = tag;
        v.expErr = expErr;
        return v;
    endfunction

    // Offer one descriptor, record what it should produce once accepted
    task automatic applyStimulus(input vec_t v, output int nWaits);
        bit accepted;
        cpl_t c;
        job_t j;
        accepted = 0;
        nWaits = 0;
        desc_src = v.src;
        desc_dest = v.dest;
        desc_len = v.len;
        desc_mask = v.mask;
        desc_tag = v.tag;
        desc_valid = 1'b1;
        while (!accepted && nWaits < 300) begin
            @(negedge aclk);
            if (desc_ready) accepted = 1;
            else nWaits++;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: tag %0d never accepted", v.tag);
        end else begin
            c.tag = v.tag;
            c.err = v.expErr;
            expQ.push_back(c);
            if (!v.expErr) begin
                j.src = v.src;
                j.dest = v.dest;
                j.len = v.len;
                j.mask = v.mask;
                expJobQ.push_back(j);
            end
        end
        @(posedge aclk);
        #1;
        desc_valid = 1'b0;
    endtask

    // Wait until every expected completion is seen and the sequencer is idle
    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || busy) && n < 1000) begin
            @(negedge aclk);
            n++;
        end
        checkOutput({name, "_drained"}, 64'(expQ.size() == 0 && !busy), 64'(1));
        @(posedge aclk);
        #1;
    endtask

    // Mover model: drops done after a job pulse, raises it 10 cycles later
    always @(negedge aclk) begin
        if (areset) begin
            mv_done = 1'b1;
            moverBusy = 0;
            moverCnt = 0;
        end else if (moverBusy) begin
            moverCnt--;
            if (moverCnt == 0) begin
                mv_done = 1'b1;
                moverBusy = 0;
            end
        end else if (mv_en && !moverStuck) begin
            mv_done = 1'b0;
            moverCnt = 10;
            moverBusy = 1;
        end
    end

    // Scoreboard: compare issued jobs and completions against the queues
    always @(negedge aclk) begin
        if (!areset) begin
            if (mv_en) begin
                mvEnCount++;
                if (expJobQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_mv_en: length 0x%0h, no job expected", mv_length);
                end else begin
                    monJob = expJobQ.pop_front();
                    checkOutput("mv_src_addr", mv_src_addr, monJob.src);
                    checkOutput("mv_dest_addr", mv_dest_addr, monJob.dest);
                    checkOutput("mv_length", mv_length, monJob.len);
                    checkOutput("mv_mask", 64'(mv_mask), 64'(monJob.mask));
                end
                lastLen = mv_length;
            end
            if (!mv_done) begin
                checkOutput("mv_length_stable", mv_length, lastLen);
            end
            if (cpl_valid && cpl_ready) begin
                cplCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_cpl: tag %0d err %0d, none expected", cpl_tag, cpl_err);
                end else begin
                    monCpl = expQ.pop_front();
                    checkOutput("cpl_tag", 64'(cpl_tag), 64'(monCpl.tag));
                    checkOutput("cpl_err", 64'(cpl_err), 64'(monCpl.err));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{64'h1000, 64'h2000, 64'h40, 8'hFF, 4'd3, 1'b0};
        vecs[1] = '{64'h1000, 64'h2000, 64'h44, 8'hFF, 4'd5, 1'b1};
        vecs[2] = '{64'h1000, 64'h2000, 64'h0, 8'hFF, 4'd6, 1'b1};
        vecs[3] = '{64'h1004, 64'h2000, 64'h40, 8'h0F, 4'd7, 1'b1};
        vecs[4] = '{64'h1000, 64'h2003, 64'h40, 8'h0F, 4'd8, 1'b1};
        vecs[5] = '{64'h8, 64'h10, 64'h8, 8'h01, 4'd9, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'h10, 8'hA5, 4'd15, 1'b0};

        areset = 1'b1;
        desc_valid = 1'b0;
        desc_src = '0;
        desc_dest = '0;
        desc_len = '0;
        desc_mask = '0;
        desc_tag = '0;
        cpl_ready = 1'b1;

        // Reset values while areset is held
        repeat (2) @(negedge aclk);
        checkOutput("rst_count", 64'(count), 64'(0));
        checkOutput("rst_desc_ready", 64'(desc_ready), 64'(1));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_mv_en", 64'(mv_en), 64'(0));
        checkOutput("rst_cpl_valid", 64'(cpl_valid), 64'(0));
        checkOutput("rst_cpl_err", 64'(cpl_err), 64'(0));
        checkOutput("rst_cpl_tag", 64'(cpl_tag), 64'(0));
        checkOutput("rst_mv_length", mv_length, 64'(0));
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // Table of single jobs, each run to completion
        for (int i = 0; i < 7; i++) begin
            beforeEn = mvEnCount;
            beforeCpl = cplCount;
            applyStimulus(vecs[i], waits);
            waitDrain($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_mv_en_pulses", i), 64'(mvEnCount - beforeEn),
                        64'(vecs[i].expErr ? 0 : 1));
            checkOutput($sformatf("vec%0d_cpl_count", i), 64'(cplCount - beforeCpl), 64'(1));
        end

        // Minimum issue latency: push at edge N, mv_en during cycle N+2
        applyStimulus(mkVec(64'h3000, 64'h5000, 64'h20, 8'h33, 4'd1, 1'b0), waits);
        k = 99;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge aclk);
            if (mv_en) begin
                found = 1;
                k = i;
            end
        end
        checkOutput("issue_latency", 64'(k), 64'(2));
        waitDrain("latency");

        // Rejected job reaches completion two cycles after the push
        applyStimulus(mkVec(64'h1000, 64'h2000, 64'h44, 8'hFF, 4'd5, 1'b1), waits);
        k = 99;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge aclk);
            if (cpl_valid) begin
                found = 1;
                k = i;
            end
        end
        checkOutput("reject_latency", 64'(k), 64'(2));
        waitDrain("reject");

        // Acknowledge timeout: mover never drops done
        moverStuck = 1;
        beforeEn = mvEnCount;
        applyStimulus(mkVec(64'h6000, 64'h7000, 64'h80, 8'hFF, 4'd10, 1'b1), waits);
        expJobQ.push_back('{64'h6000, 64'h7000, 64'h80, 8'hFF});
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge aclk);
            if (mv_en) found = 1;
        end
        checkOutput("timeout_mv_en_seen", 64'(found), 64'(1));
        k = 99;
        found = 0;
        for (int i = 1; i < 30 && !found; i++) begin
            @(negedge aclk);
            if (cpl_valid) begin
                found = 1;
                k = i;
            end
        end
        checkOutput("timeout_cpl_delay", 64'(k), 64'(9));
        checkOutput("timeout_cpl_err", 64'(cpl_err), 64'(1));
        waitDrain("timeout");
        checkOutput("timeout_mv_en_pulses", 64'(mvEnCount - beforeEn), 64'(1));
        moverStuck = 0;

        // Backpressure: six jobs queued while completions are held off
        cpl_ready = 1'b0;
        bpDone = 0;
        beforeCpl = cplCount;
        fork
            begin
                for (int t = 0; t < 6; t++) begin
                    applyStimulus(mkVec(64'h4000 + 64'(t) * 64'h100, 64'h8000 + 64'(t) * 64'h100,
                                        64'h10, 8'hFF, 4'(t), 1'b0), bpWaits);
                end
                bpDone = 1;
            end
        join_none
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge aclk);
            if (count == 3'd4) found = 1;
        end
        checkOutput("bp_count_full", 64'(count), 64'(4));
        checkOutput("bp_desc_ready_low", 64'(desc_ready), 64'(0));
        repeat (20) @(negedge aclk);
        checkOutput("bp_still_full", 64'(count), 64'(4));
        checkOutput("bp_held_cpl", 64'(cpl_valid), 64'(1));
        @(posedge aclk);
        #1;
        cpl_ready = 1'b1;
        for (int i = 0; i < 500 && !bpDone; i++) @(negedge aclk);
        checkOutput("bp_all_pushed", 64'(bpDone), 64'(1));
        waitDrain("backpressure");
        checkOutput("bp_cpl_count", 64'(cplCount - beforeCpl), 64'(6));

        // Push lands on the same edge that IDLE pops the queued entry
        cpl_ready = 1'b0;
        applyStimulus(mkVec(64'h100, 64'h200, 64'h8, 8'h11, 4'd11, 1'b0), waits);
        applyStimulus(mkVec(64'h300, 64'h400, 64'h18, 8'h22, 4'd12, 1'b0), waits);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge aclk);
            if (cpl_valid) found = 1;
        end
        checkOutput("pp_first_cpl", 64'(cpl_valid), 64'(1));
        @(posedge aclk);
        #1;
        cpl_ready = 1'b1;
        @(posedge aclk);
        #1;
        checkOutput("pp_count_before", 64'(count), 64'(1));
        checkOutput("pp_in_idle", 64'(cpl_valid), 64'(0));
        applyStimulus(mkVec(64'h500, 64'h600, 64'h28, 8'h44, 4'd13, 1'b0), waits);
        checkOutput("pp_count_after", 64'(count), 64'(1));
        waitDrain("pushpop");

        // Reset while a job waits for the mover and two more are queued
        applyStimulus(mkVec(64'h900, 64'hA00, 64'h40, 8'h0F, 4'd14, 1'b0), waits);
        applyStimulus(mkVec(64'hB00, 64'hC00, 64'h40, 8'h0F, 4'd15, 1'b0), waits);
        applyStimulus(mkVec(64'hD00, 64'hE00, 64'h40, 8'h0F, 4'd2, 1'b0), waits);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge aclk);
            if (!mv_done) found = 1;
        end
        repeat (3) @(negedge aclk);
        checkOutput("mid_pre_count", 64'(count), 64'(2));
        checkOutput("mid_pre_busy", 64'(busy), 64'(1));
        #1;
        areset = 1'b1;
        #1;
        checkOutput("mid_count", 64'(count), 64'(0));
        checkOutput("mid_desc_ready", 64'(desc_ready), 64'(1));
        checkOutput("mid_busy", 64'(busy), 64'(0));
        checkOutput("mid_mv_en", 64'(mv_en), 64'(0));
        checkOutput("mid_cpl_valid", 64'(cpl_valid), 64'(0));
        checkOutput("mid_cpl_tag", 64'(cpl_tag), 64'(0));
        checkOutput("mid_mv_length", mv_length, 64'(0));
        checkOutput("mid_mv_src", mv_src_addr, 64'(0));
        checkOutput("mid_mv_mask", 64'(mv_mask), 64'(0));
        expQ.delete();
        expJobQ.delete();
        beforeEn = mvEnCount;
        beforeCpl = cplCount;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        applyStimulus(mkVec(64'hF00, 64'hF80, 64'h8, 8'h77, 4'd4, 1'b0), waits);
        checkOutput("post_rst_first_push_waits", 64'(waits), 64'(0));
        waitDrain("postreset");
        repeat (20) @(negedge aclk);
        checkOutput("post_rst_cpl_count", 64'(cplCount - beforeCpl), 64'(1));
        checkOutput("post_rst_mv_en_pulses", 64'(mvEnCount - beforeEn), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
